// File: rtl/led_pwm_fader_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// led_pwm_pkg: timing helpers and output polarity constants
// Revision: 1.0
// ------------------------------------------------------------------
package led_pwm_pkg;

   localparam logic c_filament_on_value  = 1'b1;
   localparam logic c_filament_off_value = 1'b0;

   function automatic int unsigned f_period_cycles(input int unsigned fclk,
                                                   input int unsigned period_ms);
      return fclk / 1000 * period_ms;
   endfunction

   function automatic int unsigned f_duty_max(input int unsigned period,
                                              input int unsigned max_pct);
      return period / 100 * max_pct;
   endfunction

   function automatic int unsigned f_duty_ratio(input int unsigned duty_max,
                                                input int unsigned level_bits);
      return duty_max / ((32'd1 << level_bits) - 32'd1);
   endfunction

   function automatic int unsigned f_count_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/led_pwm_fader_if.sv
`default_nettype none
// ------------------------------------------------------------------
// led_pwm_fader_if: target-level load handshake
// Revision: 1.0
// ------------------------------------------------------------------
interface led_pwm_fader_if #(
   parameter int unsigned parm_channel_count = 8,
   parameter int unsigned parm_level_bits    = 8
);
   logic [parm_channel_count*parm_level_bits-1:0] target_level;
   logic                                          load_valid;
   logic                                          load_ready;

   modport master (output target_level, output load_valid, input load_ready);
   modport slave  (input target_level, input load_valid, output load_ready);
endinterface
`default_nettype wire

// File: rtl/led_pwm_channel.sv
`default_nettype none
// ------------------------------------------------------------------
// led_pwm_channel: fading level, duty pipeline, phased compare
// Revision: 1.0
// ------------------------------------------------------------------
module led_pwm_channel
   import led_pwm_pkg::*;
#(
   parameter int unsigned parm_level_bits  = 8,
   parameter int unsigned parm_count_bits  = 19,
   parameter int unsigned parm_period      = 400000,
   parameter int unsigned parm_ratio       = 1254,
   parameter int unsigned parm_offset      = 0,
   parameter bit          parm_active_high = 1'b1
) (
   input  logic                       clk_i,
   input  logic                       srst_n_i,
   input  logic [parm_count_bits-1:0] count_i,
   input  logic                       boundary_i,
   input  logic [parm_level_bits-1:0] target_i,
   input  logic [parm_level_bits-1:0] fade_step_i,
   input  logic                       enable_i,
   output logic                       busy_next_o,
   output logic                       pwm_o
);

   localparam int unsigned c_lb = parm_level_bits;
   localparam int unsigned c_cb = parm_count_bits;
   localparam logic [c_cb:0]   c_period_w = parm_period[c_cb:0];
   localparam logic [c_cb:0]   c_offset_w = parm_offset[c_cb:0];
   localparam logic [c_cb-1:0] c_ratio_w  = parm_ratio[c_cb-1:0];
   localparam logic c_on  = parm_active_high ? c_filament_on_value  : c_filament_off_value;
   localparam logic c_off = parm_active_high ? c_filament_off_value : c_filament_on_value;

   logic [c_lb-1:0] level_q, level_d;
   logic [c_lb-1:0] stage1_q;
   logic [c_cb-1:0] stage2_q, stage2_d;
   logic [c_cb-1:0] duty_q, duty_d;
   logic [c_lb:0]   up_sum, dn_diff;
   logic [c_cb:0]   phased_sum, phased;
   logic            on_now;
   logic            pwm_q, pwm_d;

   // Fade arithmetic carries one extra bit so neither direction wraps.
   always_comb begin
      up_sum  = {1'b0, level_q} + {1'b0, fade_step_i};
      dn_diff = {1'b0, level_q} - {1'b0, fade_step_i};
      level_d = level_q;
      if (boundary_i) begin
         if (fade_step_i == '0) begin
            level_d = target_i;
         end else if (level_q < target_i) begin
            level_d = (up_sum > {1'b0, target_i}) ? target_i : up_sum[c_lb-1:0];
         end else if (level_q > target_i) begin
            level_d = (dn_diff[c_lb] || (dn_diff[c_lb-1:0] < target_i)) ? target_i
                                                                       : dn_diff[c_lb-1:0];
         end
      end
   end

   assign busy_next_o = (level_d != target_i);

   always_comb begin
      stage2_d   = c_ratio_w * c_cb'(stage1_q);
      duty_d     = boundary_i ? stage2_q : duty_q;
      phased_sum = {1'b0, count_i} + c_offset_w;
      phased     = (phased_sum >= c_period_w) ? (phased_sum - c_period_w) : phased_sum;
      on_now     = enable_i && (phased < {1'b0, duty_q});
      pwm_d      = on_now ? c_on : c_off;
   end

   always_ff @(posedge clk_i) begin
      if (!srst_n_i) begin
         level_q  <= '0;
         stage1_q <= '0;
         stage2_q <= '0;
         duty_q   <= '0;
         pwm_q    <= c_off;
      end else begin
         level_q  <= level_d;
         stage1_q <= level_q;
         stage2_q <= stage2_d;
         duty_q   <= duty_d;
         pwm_q    <= pwm_d;
      end
   end

   assign pwm_o = pwm_q;

endmodule
`default_nettype wire

// File: rtl/led_pwm_fader.sv
`default_nettype none
// ------------------------------------------------------------------
// led_pwm_fader: N-channel PWM driver with buffered load and fading
// Revision: 1.0
// ------------------------------------------------------------------
module led_pwm_fader
   import led_pwm_pkg::*;
#(
   parameter int unsigned parm_channel_count           = 8,
   parameter int unsigned parm_level_bits              = 8,
   parameter int unsigned parm_FCLK                    = 40_000_000,
   parameter int unsigned parm_pwm_period_milliseconds = 10,
   parameter int unsigned parm_max_duty_percent        = 80,
   parameter int unsigned parm_phase_stagger           = 1,
   parameter int unsigned parm_active_high             = 1
) (
   input  logic                          i_clk,
   input  logic                          i_srst_n,
   led_pwm_fader_if.slave                load_if,
   input  logic [parm_level_bits-1:0]    i_fade_step,
   input  logic                          i_enable,
   output logic                          o_period_strobe,
   output logic                          o_fade_busy,
   output logic [parm_channel_count-1:0] eo_pwm
);

   localparam int unsigned c_chans  = parm_channel_count;
   localparam int unsigned c_lb     = parm_level_bits;
   localparam int unsigned c_period = f_period_cycles(parm_FCLK, parm_pwm_period_milliseconds);
   localparam int unsigned c_ratio  =
      f_duty_ratio(f_duty_max(c_period, parm_max_duty_percent), parm_level_bits);
   localparam int unsigned c_cnt_w  = f_count_width(c_period);
   localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(c_period - 1);

   logic [c_cnt_w-1:0]      count_q, count_d;
   logic                    strobe_q, strobe_d;
   logic                    at_boundary;
   logic                    accept;
   logic                    pending_flag_q, pending_flag_d;
   logic [c_chans*c_lb-1:0] pending_q, pending_d;
   logic [c_chans*c_lb-1:0] target_q, target_d;
   logic                    ready_q, ready_d;
   logic                    busy_q, busy_d;
   logic [c_chans-1:0]      chan_busy;

   assign at_boundary = (count_q == c_last);
   assign accept      = load_if.load_valid && ready_q;

   always_comb begin
      count_d  = at_boundary ? '0 : count_q + c_cnt_w'(1);
      strobe_d = (count_d == c_last);
   end

   // A load taken on the boundary cycle only sets pending, so it waits a full period.
   always_comb begin
      pending_d      = pending_q;
      pending_flag_d = pending_flag_q;
      target_d       = target_q;
      if (at_boundary && pending_flag_q) begin
         target_d       = pending_q;
         pending_flag_d = 1'b0;
      end
      if (accept) begin
         pending_d      = load_if.target_level;
         pending_flag_d = 1'b1;
      end
      ready_d = !pending_flag_d;
   end

   assign busy_d = at_boundary ? (|chan_busy) : busy_q;

   always_ff @(posedge i_clk) begin
      if (!i_srst_n) begin
         count_q        <= '0;
         strobe_q       <= 1'b0;
         pending_flag_q <= 1'b0;
         pending_q      <= '0;
         target_q       <= '0;
         ready_q        <= 1'b0;
         busy_q         <= 1'b0;
      end else begin
         count_q        <= count_d;
         strobe_q       <= strobe_d;
         pending_flag_q <= pending_flag_d;
         pending_q      <= pending_d;
         target_q       <= target_d;
         ready_q        <= ready_d;
         busy_q         <= busy_d;
      end
   end

   assign load_if.load_ready = ready_q;
   assign o_period_strobe    = strobe_q;
   assign o_fade_busy        = busy_q;

   for (genvar k = 0; k < c_chans; k++) begin : g_channel
      localparam int unsigned c_offset =
         (parm_phase_stagger != 0) ? (int'(k) * (c_period / c_chans)) : 0;

      led_pwm_channel #(
         .parm_level_bits  (c_lb),
         .parm_count_bits  (c_cnt_w),
         .parm_period      (c_period),
         .parm_ratio       (c_ratio),
         .parm_offset      (c_offset),
         .parm_active_high (parm_active_high != 0)
      ) u_channel (
         .clk_i       (i_clk),
         .srst_n_i    (i_srst_n),
         .count_i     (count_q),
         .boundary_i  (at_boundary),
         .target_i    (target_d[k*c_lb +: c_lb]),
         .fade_step_i (i_fade_step),
         .enable_i    (i_enable),
         .busy_next_o (chan_busy[k]),
         .pwm_o       (eo_pwm[k])
      );
   end

endmodule
`default_nettype wire

// File: tb/tb_led_pwm_fader.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_led_pwm_fader: staggered/active-high and aligned/active-low DUTs vs reference model
// Revision: 1.0
// ------------------------------------------------------------------
module tb_led_pwm_fader;

   localparam int c_chans = 4;
   localparam int c_lb    = 4;
   localparam int c_p     = 100;
   localparam int c_r     = 5;

   logic                    clk;
   logic                    srst_n;
   logic [c_chans*c_lb-1:0] target_level;
   logic                    load_valid;
   logic [c_lb-1:0]         fade_step;
   logic                    enable;
   logic                    strobe_a, busy_a, strobe_b, busy_b;
   logic [c_chans-1:0]      pwm_a, pwm_b;

   int n_checks = 0;
   int n_fail   = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   led_pwm_fader_if #(.parm_channel_count(c_chans), .parm_level_bits(c_lb)) if_a ();
   led_pwm_fader_if #(.parm_channel_count(c_chans), .parm_level_bits(c_lb)) if_b ();

   assign if_a.target_level = target_level;
   assign if_a.load_valid   = load_valid;
   assign if_b.target_level = target_level;
   assign if_b.load_valid   = load_valid;

   led_pwm_fader #(
      .parm_channel_count(c_chans), .parm_level_bits(c_lb), .parm_FCLK(100_000),
      .parm_pwm_period_milliseconds(1), .parm_max_duty_percent(80),
      .parm_phase_stagger(1), .parm_active_high(1)
   ) dut_a (
      .i_clk(clk), .i_srst_n(srst_n), .load_if(if_a.slave), .i_fade_step(fade_step),
      .i_enable(enable), .o_period_strobe(strobe_a), .o_fade_busy(busy_a), .eo_pwm(pwm_a)
   );

   led_pwm_fader #(
      .parm_channel_count(c_chans), .parm_level_bits(c_lb), .parm_FCLK(100_000),
      .parm_pwm_period_milliseconds(1), .parm_max_duty_percent(80),
      .parm_phase_stagger(0), .parm_active_high(0)
   ) dut_b (
      .i_clk(clk), .i_srst_n(srst_n), .load_if(if_b.slave), .i_fade_step(fade_step),
      .i_enable(enable), .o_period_strobe(strobe_b), .o_fade_busy(busy_b), .eo_pwm(pwm_b)
   );

   // Reference model state: value of each quantity during the current cycle.
   int               m_cnt;
   bit               m_pend;
   int               m_pending [c_chans];
   int               m_target  [c_chans];
   int               m_cur     [c_chans];
   int               m_duty    [c_chans];
   bit               m_ready, m_strobe, m_busy;
   bit [c_chans-1:0] m_on_a, m_on_b;

   int meas_hi_a [c_chans];
   int meas_hi_b [c_chans];
   int meas_rise_a [c_chans];
   int meas_rise_b [c_chans];
   bit samp_a [c_chans][c_p];
   bit samp_b [c_chans][c_p];

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic int fade_level(input int cur, input int tgt, input int step);
      if (step == 0) return tgt;
      if (cur < tgt) return (cur + step > tgt) ? tgt : cur + step;
      if (cur > tgt) return (cur - step < tgt) ? tgt : cur - step;
      return cur;
   endfunction

   task automatic model_step();
      bit bnd;
      bit take;
      if (!srst_n) begin
         m_cnt = 0; m_pend = 0; m_ready = 0; m_strobe = 0; m_busy = 0;
         m_on_a = '0; m_on_b = '0;
         for (int k = 0; k < c_chans; k++) begin
            m_pending[k] = 0; m_target[k] = 0; m_cur[k] = 0; m_duty[k] = 0;
         end
      end else begin
         bnd  = (m_cnt == c_p - 1);
         take = load_valid && m_ready;
         for (int k = 0; k < c_chans; k++) begin
            m_on_a[k] = enable && (((m_cnt + k * (c_p / c_chans)) % c_p) < m_duty[k]);
            m_on_b[k] = enable && (m_cnt < m_duty[k]);
         end
         if (bnd) begin
            for (int k = 0; k < c_chans; k++) m_duty[k] = c_r * m_cur[k];
            if (m_pend) begin
               for (int k = 0; k < c_chans; k++) m_target[k] = m_pending[k];
               m_pend = 0;
            end
            m_busy = 0;
            for (int k = 0; k < c_chans; k++) begin
               m_cur[k] = fade_level(m_cur[k], m_target[k], int'(fade_step));
               if (m_cur[k] != m_target[k]) m_busy = 1;
            end
         end
         if (take) begin
            for (int k = 0; k < c_chans; k++) m_pending[k] = int'(target_level[k*c_lb +: c_lb]);
            m_pend = 1;
         end
         m_ready  = !m_pend;
         m_cnt    = bnd ? 0 : m_cnt + 1;
         m_strobe = (m_cnt == c_p - 1);
      end
   endtask

   task automatic compare_all();
      bit [c_chans-1:0] exp_b;
      exp_b = ~m_on_b;
      check_eq("pwm_a", pwm_a, m_on_a);
      check_eq("pwm_b", pwm_b, exp_b);
      check_eq("ready_a", if_a.load_ready, m_ready);
      check_eq("ready_b", if_b.load_ready, m_ready);
      check_eq("strobe_a", strobe_a, m_strobe);
      check_eq("strobe_b", strobe_b, m_strobe);
      check_eq("busy_a", busy_a, m_busy);
      check_eq("busy_b", busy_b, m_busy);
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare_all();
   endtask

   task automatic wait_boundary();
      int n = 0;
      do begin
         tick();
         n++;
      end while (m_cnt != 0 && n < 2 * c_p);
   endtask

   task automatic wait_count(input int c);
      int n = 0;
      while (m_cnt != c && n < 2 * c_p) begin
         tick();
         n++;
      end
   endtask

   task automatic do_load(input logic [c_chans*c_lb-1:0] lv);
      int n = 0;
      while (!m_ready && n < 3 * c_p) begin
         tick();
         n++;
      end
      target_level = lv;
      load_valid   = 1'b1;
      tick();
      load_valid   = 1'b0;
   endtask

   // One full period starting at count 0; active time and rising-edge index per channel.
   task automatic measure_period();
      for (int i = 0; i < c_p; i++) begin
         tick();
         for (int k = 0; k < c_chans; k++) begin
            samp_a[k][i] = (pwm_a[k] === 1'b1);
            samp_b[k][i] = (pwm_b[k] === 1'b0);
         end
      end
      for (int k = 0; k < c_chans; k++) begin
         meas_hi_a[k] = 0; meas_hi_b[k] = 0; meas_rise_a[k] = -1; meas_rise_b[k] = -1;
         for (int i = 0; i < c_p; i++) begin
            if (samp_a[k][i]) meas_hi_a[k]++;
            if (samp_b[k][i]) meas_hi_b[k]++;
            if (samp_a[k][i] && !samp_a[k][(i + c_p - 1) % c_p] && meas_rise_a[k] < 0)
               meas_rise_a[k] = i;
            if (samp_b[k][i] && !samp_b[k][(i + c_p - 1) % c_p] && meas_rise_b[k] < 0)
               meas_rise_b[k] = i;
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      srst_n       = 1'b0;
      load_valid   = 1'b1;
      target_level = 16'hA5C3;
      fade_step    = '0;
      enable       = 1'b1;

      for (int i = 0; i < 5; i++) begin
         tick();
         check_eq("rst_ready", if_a.load_ready, 0);
         check_eq("rst_pwm_a", pwm_a, 4'h0);
         check_eq("rst_pwm_b", pwm_b, 4'hF);
      end
      srst_n = 1'b1;
      tick();
      check_eq("rel_ready", if_a.load_ready, 1);
      load_valid = 1'b0;
      wait_boundary();
      check_eq("rst_noload_busy", busy_a, 0);

      // Instant load of ch0 = 15 mid-period.
      wait_count(50);
      do_load(16'h000F);
      wait_boundary();
      wait_boundary();
      measure_period();
      check_eq("inst_hi_ch0", meas_hi_a[0], 75);
      check_eq("inst_lo_ch0_b", meas_hi_b[0], 75);
      for (int k = 1; k < c_chans; k++) check_eq("inst_hi_other", meas_hi_a[k], 0);

      // Fade 0 -> 15 with step 4.
      do_load(16'h0000);
      wait_boundary();
      fade_step = 4'd4;
      do_load(16'h000F);
      wait_boundary();
      check_eq("fade_busy_b1", busy_a, 1);
      wait_boundary();
      check_eq("fade_busy_b2", busy_a, 1);
      measure_period();
      check_eq("fade_hi_lvl4", meas_hi_a[0], 20);
      measure_period();
      check_eq("fade_hi_lvl8", meas_hi_a[0], 40);
      check_eq("fade_busy_done", busy_a, 0);
      measure_period();
      check_eq("fade_hi_lvl12", meas_hi_a[0], 60);
      measure_period();
      check_eq("fade_hi_lvl15", meas_hi_a[0], 75);

      // Stagger: all channels at level 8.
      fade_step = '0;
      do_load(16'h8888);
      wait_boundary();
      wait_boundary();
      measure_period();
      for (int k = 0; k < c_chans; k++) begin
         check_eq("stag_hi_a", meas_hi_a[k], 40);
         check_eq("stag_rise_a", meas_rise_a[k], (c_p - k * (c_p / c_chans)) % c_p);
         check_eq("stag_hi_b", meas_hi_b[k], 40);
         check_eq("stag_rise_b", meas_rise_b[k], 0);
      end

      // Load on the boundary cycle, then a second request while pending.
      wait_count(c_p - 1);
      target_level = 16'h0003;
      load_valid   = 1'b1;
      tick();
      check_eq("corner_ready_lo", if_a.load_ready, 0);
      target_level = 16'h000C;
      for (int i = 0; i < 5; i++) begin
         tick();
         check_eq("corner_hold_ready", if_a.load_ready, 0);
      end
      load_valid = 1'b0;
      wait_boundary();
      check_eq("corner_ready_hi", if_a.load_ready, 1);
      measure_period();
      check_eq("corner_late_ch0", meas_hi_a[0], 40);
      check_eq("corner_late_ch1", meas_hi_a[1], 40);
      measure_period();
      check_eq("corner_applied_ch0", meas_hi_a[0], 15);
      check_eq("corner_applied_ch1", meas_hi_a[1], 0);

      // Enable low mid-period while a fade is in progress.
      wait_count(10);
      enable = 1'b0;
      tick();
      check_eq("dis_pwm_a", pwm_a, 4'h0);
      check_eq("dis_pwm_b", pwm_b, 4'hF);
      fade_step = 4'd3;
      do_load(16'hFFFF);
      wait_boundary();
      wait_boundary();
      check_eq("dis_busy", busy_a, 1);
      enable = 1'b1;
      wait_boundary();
      measure_period();

      // Randomised traffic, including occasional resets.
      for (int i = 0; i < 3000; i++) begin
         srst_n       = ($urandom_range(0, 599) != 0);
         load_valid   = ($urandom_range(0, 2) == 0);
         target_level = 16'($urandom);
         if ($urandom_range(0, 49) == 0) fade_step = 4'($urandom);
         enable       = ($urandom_range(0, 7) != 0);
         tick();
      end
      srst_n = 1'b1;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
